instr_encoder: RTL and testbench

- Packs field-level instruction descriptions into the 32-bit block instruction word that the block instruction decoder consumes.
- Streams the packed words, with sequential addresses, into a block's instruction memory.
- Sits between the configuration front-end (SPI/command parser) and each DSP block's program store.
- Pads the unused tail of the program with NOPs and flags illegal or overflowing programs.

---
 rtl/instr_encoder_pkg.sv | 37 +++
 rtl/instr_encoder_pack.sv | 26 ++
 rtl/instr_encoder.sv | 104 ++++++++++
 tb/tb_instr_encoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: opcodes, field positions, NOP word and FSM states shared by encoder and decoder
package instr_encoder_pkg;
  localparam logic [4:0] BLOCK_INSTR_MADD        = 5'h00;
  localparam logic [4:0] BLOCK_INSTR_MSUB        = 5'h01;
  localparam logic [4:0] BLOCK_INSTR_MUL         = 5'h02;
  localparam logic [4:0] BLOCK_INSTR_ADD         = 5'h03;
  localparam logic [4:0] BLOCK_INSTR_SUB         = 5'h04;
  localparam logic [4:0] BLOCK_INSTR_ABS         = 5'h05;
  localparam logic [4:0] BLOCK_INSTR_MAX         = 5'h06;
  localparam logic [4:0] BLOCK_INSTR_MIN         = 5'h07;
  localparam logic [4:0] BLOCK_INSTR_DELAY_READ  = 5'h08;
  localparam logic [4:0] BLOCK_INSTR_DELAY_WRITE = 5'h09;
  localparam logic [4:0] BLOCK_INSTR_LUT_READ    = 5'h0A;
  localparam logic [4:0] BLOCK_INSTR_MEM_READ    = 5'h0B;
  localparam logic [4:0] BLOCK_INSTR_MEM_WRITE   = 5'h0C;
  localparam int POS_OP        = 0;
  localparam int POS_FMT       = 5;
  localparam int POS_SRC_A     = 6;
  localparam int POS_SRC_B     = 11;
  localparam int POS_SRC_C     = 16;
  localparam int POS_A_DEST    = 21;
  localparam int POS_SHIFT     = 25;
  localparam int POS_SAT_DIS   = 30;
  localparam int POS_SHIFT_DIS = 31;
  localparam int POS_B_DEST    = 16;
  localparam int POS_RES_ADDR  = 20;
  // MADD, format A, all-zero sources, shift disabled
  localparam logic [31:0] NOP_WORD = 32'h8000_0000;
  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_PAD, S_DONE} state_t;
  function automatic logic is_fmt_b(input logic [4:0] op);
    return op inside {BLOCK_INSTR_DELAY_READ, BLOCK_INSTR_DELAY_WRITE, BLOCK_INSTR_LUT_READ,
                      BLOCK_INSTR_MEM_READ, BLOCK_INSTR_MEM_WRITE};
  endfunction
  function automatic logic is_legal(input logic [4:0] op);
    return op <= BLOCK_INSTR_MEM_WRITE;
  endfunction
endpackage

// File: rtl/instr_encoder_pack.sv
// instr_encoder_pack: combinational field bundle -> 32-bit instruction word plus legality flag
module instr_encoder_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  i_operation,
  input  logic [4:0]  i_src_a,
  input  logic [4:0]  i_src_b,
  input  logic [4:0]  i_src_c,
  input  logic [3:0]  i_dest,
  input  logic [4:0]  i_shift,
  input  logic        i_saturate_disable,
  input  logic        i_shift_disable,
  input  logic [11:0] i_res_addr,
  output logic [31:0] o_word,
  output logic        o_legal
);
  logic w_fmt_b;
  // format B trades src_c/shift/flags for a 12-bit resource address
  always_comb begin
    w_fmt_b = is_fmt_b(i_operation);
    o_legal = is_legal(i_operation);
    o_word  = w_fmt_b ? {i_res_addr, i_dest, i_src_b, i_src_a, 1'b1, i_operation}
                      : {i_shift_disable, i_saturate_disable, i_shift, i_dest, i_src_c,
                         i_src_b, i_src_a, 1'b0, i_operation};
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction bundles and streams them, NOP-padded, into block instruction memory
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int N_INSTRS = 256,
  parameter int ADDR_W   = $clog2(N_INSTRS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_operation,
  input  logic [4:0]        in_src_a,
  input  logic [4:0]        in_src_b,
  input  logic [4:0]        in_src_c,
  input  logic [3:0]        in_dest,
  input  logic [4:0]        in_shift,
  input  logic              in_saturate_disable,
  input  logic              in_shift_disable,
  input  logic [11:0]       in_res_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam logic [ADDR_W:0] L_FULL = (ADDR_W+1)'(N_INSTRS);
  state_t          r_state, w_state_nxt;
  logic [ADDR_W:0] r_addr, w_next_addr;
  logic            r_out_valid, r_error;
  logic [31:0]     r_out_data, w_word, w_load_data;
  logic            w_legal, w_fire_out, w_slot_free, w_room, w_in_fire, w_load, w_err;
  instr_encoder_pack u_pack (
    .i_operation        (in_operation),
    .i_src_a            (in_src_a),
    .i_src_b            (in_src_b),
    .i_src_c            (in_src_c),
    .i_dest             (in_dest),
    .i_shift            (in_shift),
    .i_saturate_disable (in_saturate_disable),
    .i_shift_disable    (in_shift_disable),
    .i_res_addr         (in_res_addr),
    .o_word             (w_word),
    .o_legal            (w_legal)
  );
  // r_addr is the pending word's address while valid, else the count of words written
  always_comb begin
    w_fire_out  = r_out_valid & out_ready;
    w_next_addr = r_addr + {{ADDR_W{1'b0}}, w_fire_out};
    w_slot_free = !r_out_valid | out_ready;
    w_room      = w_next_addr != L_FULL;
    w_in_fire   = (r_state == S_ACCEPT) & in_valid & w_slot_free;
    w_load      = (w_in_fire & w_legal & w_room) | ((r_state == S_PAD) & w_slot_free & w_room);
    w_load_data = (r_state == S_PAD) ? NOP_WORD : w_word;
    w_err       = w_in_fire & !(w_legal & w_room);
  end
  // next state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = (r_state == S_ACCEPT) & w_slot_free;
    busy        = (r_state == S_ACCEPT) | (r_state == S_PAD);
    done        = r_state == S_DONE;
    if (start) w_state_nxt = S_ACCEPT;
    else if (r_state == S_IDLE) w_state_nxt = S_IDLE;
    else if (r_state == S_ACCEPT && finish) w_state_nxt = (w_slot_free & !w_room) ? S_DONE : S_PAD;
    else if (r_state == S_PAD && w_slot_free && !w_room) w_state_nxt = S_DONE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end
  // single-entry output register, address counter and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_error     <= 1'b0;
    end else if (start) begin
      r_addr      <= '0;
      r_out_valid <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
        r_addr      <= w_next_addr;
      end else if (w_fire_out) begin
        r_out_valid <= 1'b0;
        r_addr      <= w_next_addr;
      end
      if (w_err) r_error <= 1'b1;
    end
  end
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_addr[ADDR_W-1:0];
  assign error     = r_error;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder with an 8-deep program store
module tb_instr_encoder;
  localparam int N = 8;
  localparam int AW = 3;
  localparam logic [31:0] NOP = 32'h8000_0000;
  logic clk = 1'b0;
  logic reset, start, finish, in_valid, in_ready, out_valid, out_ready, busy, done, error;
  logic [4:0] in_operation, in_src_a, in_src_b, in_src_c, in_shift;
  logic [3:0] in_dest;
  logic in_saturate_disable, in_shift_disable;
  logic [11:0] in_res_addr;
  logic [AW-1:0] out_addr;
  logic [31:0] out_data;
  int checks = 0;
  int failures = 0;
  instr_encoder #(.N_INSTRS(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_operation(in_operation),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_src_c(in_src_c), .in_dest(in_dest),
    .in_shift(in_shift), .in_saturate_disable(in_saturate_disable),
    .in_shift_disable(in_shift_disable), .in_res_addr(in_res_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic bundle(input logic [4:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [3:0] d, input logic [4:0] sh,
                        input logic sat, input logic shd, input logic [11:0] res);
    in_valid = 1'b1;
    in_operation = op; in_src_a = a; in_src_b = b; in_src_c = c; in_dest = d;
    in_shift = sh; in_saturate_disable = sat; in_shift_disable = shd; in_res_addr = res;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_addr"}, 32'(out_addr), 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0; out_ready = 1'b1;
    bundle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("accept_busy", 32'(busy), 1);
    chk("accept_in_ready", 32'(in_ready), 1);
    // format A MADD
    bundle(5'h00, 5'h13, 5'h02, 5'h04, 4'd7, 5'd3, 1'b1, 1'b0, 12'h000);
    tick();
    chk("madd_valid", 32'(out_valid), 1);
    chk("madd_addr", 32'(out_addr), 0);
    chk("madd_data", out_data, 32'h46E4_14C0);
    chk("madd_dest", 32'(out_data[24:21]), 7);
    chk("madd_shift", 32'(out_data[29:25]), 3);
    chk("madd_fmt", 32'(out_data[5]), 0);
    // format B LUT_READ; src_c/shift/flags must be ignored
    bundle(5'h0A, 5'h01, 5'h00, 5'h1F, 4'd2, 5'h1F, 1'b1, 1'b0, 12'hA5C);
    tick();
    chk("lut_addr", 32'(out_addr), 1);
    chk("lut_data", out_data, 32'hA5C2_006A);
    chk("lut_fmt", 32'(out_data[5]), 1);
    chk("lut_res", 32'(out_data[31:20]), 32'hA5C);
    chk("lut_dest", 32'(out_data[19:16]), 2);
    // backpressure: held word stays put and nothing new is accepted
    out_ready = 1'b0;
    bundle(5'h03, 5'h11, 5'h00, 5'h00, 4'd1, 5'd0, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_addr", 32'(out_addr), 1);
      chk("bp_data", out_data, 32'hA5C2_006A);
    end
    out_ready = 1'b1;
    tick();
    chk("b2b_addr2", 32'(out_addr), 2);
    chk("b2b_data2", out_data, 32'h0020_0443);
    bundle(5'h04, 5'h00, 5'h1F, 5'h00, 4'd15, 5'd31, 1'b0, 1'b1, 12'h000);
    tick();
    chk("b2b_addr3", 32'(out_addr), 3);
    chk("b2b_data3", out_data, 32'hBFE0_F804);
    chk("b2b_valid3", 32'(out_valid), 1);
    // illegal opcode: accepted, not written, address unchanged
    bundle(5'h1F, 5'h00, 5'h00, 5'h00, 4'd0, 5'd0, 1'b0, 1'b0, 12'h000);
    #1;
    chk("illegal_in_ready", 32'(in_ready), 1);
    tick();
    chk("illegal_error", 32'(error), 1);
    chk("illegal_no_write", 32'(out_valid), 0);
    bundle(5'h02, 5'h02, 5'h00, 5'h00, 4'd0, 5'd0, 1'b0, 1'b0, 12'h000);
    tick();
    in_valid = 1'b0;
    chk("after_illegal_addr", 32'(out_addr), 4);
    chk("after_illegal_data", out_data, 32'h0000_0082);
    chk("error_sticky", 32'(error), 1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clears_error", 32'(error), 0);
    chk("start_addr", 32'(out_addr), 0);
    chk("start_valid", 32'(out_valid), 0);
    // three words then finish, NOP padding through the last slot
    bundle(5'h00, 5'h01, 5'h00, 5'h00, 4'd0, 5'd0, 1'b0, 1'b0, 12'h000);
    tick();
    chk("pad_w0", out_data, 32'h0000_0040);
    bundle(5'h03, 5'h00, 5'h00, 5'h00, 4'd0, 5'd0, 1'b0, 1'b0, 12'h000);
    tick();
    chk("pad_w1", out_data, 32'h0000_0003);
    bundle(5'h04, 5'h00, 5'h00, 5'h00, 4'd0, 5'd0, 1'b0, 1'b0, 12'h000);
    finish = 1'b1;
    tick();
    in_valid = 1'b0; finish = 1'b0;
    chk("pad_w2_addr", 32'(out_addr), 2);
    chk("pad_w2", out_data, 32'h0000_0004);
    for (int k = 3; k < N; k++) begin
      tick();
      chk("pad_nop_addr", 32'(out_addr), 32'(k));
      chk("pad_nop_data", out_data, NOP);
      chk("pad_busy", 32'(busy), 1);
    end
    tick();
    chk("pad_done", 32'(done), 1);
    chk("pad_not_busy", 32'(busy), 0);
    chk("pad_idle_out", 32'(out_valid), 0);
    // overflow: ninth bundle dropped, finish jumps to DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N + 1; i++) begin
      bundle(5'h00, 5'(i), 5'h00, 5'h00, 4'd0, 5'd0, 1'b0, 1'b0, 12'h000);
      tick();
      if (i < N) begin
        chk("ovf_addr", 32'(out_addr), 32'(i));
        chk("ovf_data", out_data, 32'(i) << 6);
      end
    end
    in_valid = 1'b0;
    chk("ovf_error", 32'(error), 1);
    chk("ovf_dropped", 32'(out_valid), 0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("ovf_done", 32'(done), 1);
    chk("ovf_not_busy", 32'(busy), 0);
    // reset in the middle of padding
    start = 1'b1;
    tick();
    start = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick(); tick();
    chk("midpad_busy", 32'(busy), 1);
    chk("midpad_addr", 32'(out_addr), 1);
    chk("midpad_data", out_data, NOP);
    reset = 1'b1;
    tick();
    chk_reset_outputs("midpad_reset");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("reset_over_start", 32'(busy), 0);
    reset = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
